// File: rtl/mac_core_seq_if.sv
// Command/result bus of the MAC engine: operands and command in, serial accumulator bytes out.
interface mac_core_seq_if #(
    parameter int unsigned DW = 8
);
    logic                 ena;
    logic signed [DW-1:0] a_in;
    logic signed [DW-1:0] b_in;
    logic [1:0]           op;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           res_byte;
    logic                 res_valid;
    logic                 ovf;

    modport master (
        output ena, a_in, b_in, op, in_valid,
        input  in_ready, res_byte, res_valid, ovf
    );

    modport slave (
        input  ena, a_in, b_in, op, in_valid,
        output in_ready, res_byte, res_valid, ovf
    );
endinterface

// File: rtl/mac_core_seq.sv
// Pipelined signed DWxDW multiply-accumulate with in-order CLR/LOAD and LSB-first byte readout.
module mac_core_seq #(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 24,
    parameter bit          SAT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_core_seq_if.slave bus
);
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned NB = AW / 8;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {OP_MAC = 2'b00, OP_CLR = 2'b01, OP_LOAD = 2'b10, OP_READ = 2'b11} op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SEND} state_e;

    state_e               state_q;
    logic [IW-1:0]        idx_q;
    logic                 in_ready_q, res_valid_q, ovf_q;
    logic [7:0]           res_byte_q;
    logic                 s1_v_q, s2_v_q;
    op_e                  s1_op_q, s2_op_q;
    logic signed [DW-1:0] s1_a_q, s1_b_q;
    logic signed [PW-1:0] s2_prod_q;
    logic [AW-1:0]        acc_q, acc_d;
    logic                 ovf_d;

    logic                 accept_c;
    logic                 enq_c;
    logic signed [PW-1:0] prod_c;
    logic signed [AW:0]   sum_c;
    logic [IW-1:0]        idx_nxt_c;

    assign accept_c  = bus.in_valid & in_ready_q & bus.ena;
    assign enq_c     = accept_c & (op_e'(bus.op) != OP_READ);
    assign prod_c    = PW'(s1_a_q) * PW'(s1_b_q);
    assign sum_c     = $signed({acc_q[AW-1], acc_q}) + (AW+1)'(s2_prod_q);
    assign idx_nxt_c = idx_q + IW'(1);

    // Pipeline stages; READ enters as a bubble so S1/S2 only ever carry acc-modifying ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_op_q   <= OP_MAC;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_op_q   <= OP_MAC;
            s2_prod_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (bus.ena) begin
            s1_v_q    <= enq_c;
            s1_op_q   <= op_e'(bus.op);
            s1_a_q    <= bus.a_in;
            s1_b_q    <= bus.b_in;
            s2_v_q    <= s1_v_q;
            s2_op_q   <= s1_op_q;
            s2_prod_q <= prod_c;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    // Accumulate stage; overflow when the extra sum bit disagrees with the AW-bit sign.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (s2_v_q) begin
            case (s2_op_q)
                OP_MAC: begin
                    if (sum_c[AW] != sum_c[AW-1]) begin
                        ovf_d = 1'b1;
                        if (SAT) acc_d = sum_c[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
                        else     acc_d = sum_c[AW-1:0];
                    end else begin
                        acc_d = sum_c[AW-1:0];
                    end
                end
                OP_LOAD: begin
                    acc_d = AW'(s2_prod_q);
                    ovf_d = 1'b0;
                end
                OP_CLR: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Readout sequencer; S2 empty in DRAIN means acc already holds its final value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_byte_q  <= 8'h00;
        end else if (bus.ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c && op_e'(bus.op) == OP_READ) begin
                        state_q    <= ST_DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_v_q && !s2_v_q) begin
                        state_q     <= ST_SEND;
                        idx_q       <= '0;
                        res_valid_q <= 1'b1;
                        res_byte_q  <= acc_q[7:0];
                    end
                end
                ST_SEND: begin
                    if (idx_q == IW'(NB - 1)) begin
                        state_q     <= ST_IDLE;
                        in_ready_q  <= 1'b1;
                        res_valid_q <= 1'b0;
                        res_byte_q  <= 8'h00;
                    end else begin
                        idx_q      <= idx_nxt_c;
                        res_byte_q <= acc_q[{idx_nxt_c, 3'b000} +: 8];
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A frozen block must not present a byte it will present again once ena returns.
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q & bus.ena;
    assign bus.res_byte  = (res_valid_q & bus.ena) ? res_byte_q : 8'h00;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_core_seq.sv
// Random and directed stimulus on a wrapping and a saturating instance, checked against an arithmetic model.
module tb_mac_core_seq;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 24;
    localparam int unsigned NB = AW / 8;
    localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));
    localparam longint ACC_MOD = longint'(1) <<< AW;

    logic clk = 1'b0;
    logic rst_n;
    logic ena, in_valid;
    logic [1:0] op;
    logic signed [DW-1:0] a, b;

    int n_total = 0;
    int n_bad   = 0;
    longint m_acc [2];
    bit     m_ovf [2];

    always #5 clk = ~clk;

    mac_core_seq_if #(.DW(DW)) bus_w ();
    mac_core_seq_if #(.DW(DW)) bus_s ();

    assign bus_w.ena = ena;  assign bus_w.in_valid = in_valid;  assign bus_w.op = op;
    assign bus_w.a_in = a;   assign bus_w.b_in = b;
    assign bus_s.ena = ena;  assign bus_s.in_valid = in_valid;  assign bus_s.op = op;
    assign bus_s.a_in = a;   assign bus_s.b_in = b;

    mac_core_seq #(.DW(DW), .AW(AW), .SAT(1'b0)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w));
    mac_core_seq #(.DW(DW), .AW(AW), .SAT(1'b1)) u_sat  (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // k=0 wraps modulo 2^AW, k=1 clamps; both set the sticky flag on overflow.
    task automatic model_apply(input int o, input longint av, input longint bv);
        longint p, s;
        p = av * bv;
        for (int k = 0; k < 2; k++) begin
            case (o)
                0: begin
                    s = m_acc[k] + p;
                    if (s > ACC_MAX || s < ACC_MIN) begin
                        m_ovf[k] = 1'b1;
                        if (k == 1) s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
                        else begin
                            s = s & (ACC_MOD - 1);
                            if (s > ACC_MAX) s = s - ACC_MOD;
                        end
                    end
                    m_acc[k] = s;
                end
                1: begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
                2: begin m_acc[k] = p; m_ovf[k] = 1'b0; end
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
    endtask

    task automatic send_cmd(input logic [1:0] o, input logic signed [DW-1:0] av, input logic signed [DW-1:0] bv);
        op = o; a = av; b = bv; in_valid = 1'b1; ena = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (o != 2'b11) model_apply(int'(o), longint'(av), longint'(bv));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rdy_w"}, bus_w.in_ready, 1);
        check_eq({tag, "_rdy_s"}, bus_s.in_ready, 1);
        check_eq({tag, "_vld_w"}, bus_w.res_valid, 0);
        check_eq({tag, "_vld_s"}, bus_s.res_valid, 0);
        check_eq({tag, "_byte_w"}, bus_w.res_byte, 0);
        check_eq({tag, "_ovf_w"}, bus_w.ovf, m_ovf[0]);
        check_eq({tag, "_ovf_s"}, bus_s.ovf, m_ovf[1]);
    endtask

    // mode 0: ena held high, 1: random ena plus junk commands, 2: ena low for two cycles after the first byte.
    task automatic do_read(input int mode, input bit chk_lat);
        longint exp_w, exp_s;
        int cnt_w, cnt_s, iter, first;
        exp_w = m_acc[0]; exp_s = m_acc[1];
        cnt_w = 0; cnt_s = 0; iter = 0; first = -1;
        send_cmd(2'b11, '0, '0);
        while ((cnt_w < NB || cnt_s < NB) && iter < 200) begin
            if (mode == 1) begin
                ena = ($urandom_range(0, 3) != 0);
                in_valid = 1'($urandom_range(0, 1));
                op = 2'($urandom); a = DW'($urandom); b = DW'($urandom);
            end else if (mode == 2) begin
                ena = !(iter == 2 || iter == 3);
            end
            @(negedge clk);
            check_eq("busy_w", bus_w.in_ready, 0);
            check_eq("busy_s", bus_s.in_ready, 0);
            if (!ena) check_eq("frozen_vld", bus_w.res_valid, 0);
            if (bus_w.res_valid) begin
                if (first < 0) first = iter;
                check_eq("byte_w", bus_w.res_byte, (exp_w >> (8 * cnt_w)) & 255);
                cnt_w++;
            end else begin
                check_eq("zero_w", bus_w.res_byte, 0);
            end
            if (bus_s.res_valid) begin
                check_eq("byte_s", bus_s.res_byte, (exp_s >> (8 * cnt_s)) & 255);
                cnt_s++;
            end
            iter++;
            @(posedge clk); #1;
        end
        ena = 1'b1; in_valid = 1'b0;
        check_eq("nbytes_w", cnt_w, NB);
        check_eq("nbytes_s", cnt_s, NB);
        if (chk_lat) check_eq("first_byte_lat", first, 1);
        if (mode == 2) check_eq("held_idx_iters", iter, NB + 3);
        @(negedge clk);
        check_idle_outputs("post_read");
        @(posedge clk); #1;
    endtask

    task automatic overflow_seq();
        send_cmd(2'b10, -8'sd128, -8'sd128);
        for (int i = 0; i < 511; i++) send_cmd(2'b00, -8'sd128, -8'sd128);
        send_cmd(2'b00, 8'sd1, 8'sd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        ena = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        rst_n = 1'b0;
        model_reset();
        idle(3);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Basic LOAD then MAC
        send_cmd(2'b10, 8'sd3, 8'sd4);
        send_cmd(2'b00, -8'sd2, 8'sd5);
        do_read(0, 1'b0);
        idle(3);
        do_read(0, 1'b1);

        // Back-to-back MACs from a cleared accumulator
        send_cmd(2'b01, '0, '0);
        for (int i = 0; i < 4; i++) send_cmd(2'b00, 8'sd127, 8'sd127);
        do_read(0, 1'b0);

        // CLR sits in order between MACs
        send_cmd(2'b00, 8'sd2, 8'sd3);
        send_cmd(2'b01, '0, '0);
        send_cmd(2'b00, 8'sd1, 8'sd1);
        do_read(0, 1'b0);

        // Overflow: wrap vs clamp, then CLR clears acc and flag
        overflow_seq();
        do_read(0, 1'b0);
        send_cmd(2'b01, '0, '0);
        do_read(0, 1'b0);

        // Frozen readout holds the byte index
        send_cmd(2'b10, -8'sd77, 8'sd93);
        idle(3);
        do_read(2, 1'b1);

        // Reset in the middle of SEND with a non-zero acc and a set flag
        overflow_seq();
        send_cmd(2'b11, '0, '0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus_w.res_valid) found = 1'b1;
        end
        check_eq("rst_wait_send", found, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_idle_outputs("rst_mid_send");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        do_read(0, 1'b0);

        // Randomised command mix
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_read($urandom_range(0, 1), 1'b0);
            end else if (r == 1) begin
                idle(1);
            end else if (r == 2) begin
                ena = 1'b0; in_valid = 1'b1;
                op = 2'($urandom); a = DW'($urandom); b = DW'($urandom);
                @(posedge clk); #1;
                ena = 1'b1; in_valid = 1'b0;
            end else begin
                int o;
                o = $urandom_range(0, 9);
                send_cmd((o < 7) ? 2'b00 : ((o < 9) ? 2'b10 : 2'b01), DW'($urandom), DW'($urandom));
            end
        end
        do_read(1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
